// File: rtl/mips_pkg.sv
// Shared MIPS control-encoding definitions: opcodes, ALUOp codes, instruction
// classes and the instruction-word assembler used by the program loader.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;

  typedef enum logic [2:0] {
    CL_R       = 3'd0,
    CL_LW      = 3'd1,
    CL_SW      = 3'd2,
    CL_BEQ     = 3'd3,
    CL_ADDI    = 3'd4,
    CL_ILLEGAL = 3'd5
  } instr_class_e;

  typedef struct packed {
    logic       reg_dst;
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic [1:0] alu_op;
  } ctrl_bundle_t;

  function automatic logic [31:0] encode_word(
    input logic        rtype,
    input logic [5:0]  op,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [4:0]  shamt,
    input logic [5:0]  funct,
    input logic [15:0] imm
  );
    logic [31:0] w;
    if (rtype) begin
      w = {OP_RTYPE, rs, rt, rd, shamt, funct};
    end else begin
      w = {op, rs, rt, imm};
    end
    return w;
  endfunction

endpackage

// File: rtl/instr_encoder_ctrl_classify.sv
// Combinational inverse of the main decoder: maps a control bundle to its
// instruction class and opcode; any unlisted bundle is CL_ILLEGAL.
module ctrl_classify
  import mips_pkg::*;
(
  input  ctrl_bundle_t ctrl_i,
  output instr_class_e cls_o,
  output logic [5:0]   op_o
);

  // Don't-care fields (reg_dst/mem_to_reg for SW and BEQ) are simply not tested.
  always_comb begin
    cls_o = CL_ILLEGAL;
    if (ctrl_i.reg_dst && !ctrl_i.alu_src && !ctrl_i.mem_to_reg && ctrl_i.reg_write &&
        !ctrl_i.mem_read && !ctrl_i.mem_write && !ctrl_i.branch && (ctrl_i.alu_op == ALUOP_R)) begin
      cls_o = CL_R;
    end else if (!ctrl_i.reg_dst && ctrl_i.alu_src && ctrl_i.mem_to_reg && ctrl_i.reg_write &&
                 ctrl_i.mem_read && !ctrl_i.mem_write && !ctrl_i.branch &&
                 (ctrl_i.alu_op == ALUOP_MEM)) begin
      cls_o = CL_LW;
    end else if (ctrl_i.alu_src && !ctrl_i.reg_write && !ctrl_i.mem_read && ctrl_i.mem_write &&
                 !ctrl_i.branch && (ctrl_i.alu_op == ALUOP_MEM)) begin
      cls_o = CL_SW;
    end else if (!ctrl_i.alu_src && !ctrl_i.reg_write && !ctrl_i.mem_read && !ctrl_i.mem_write &&
                 ctrl_i.branch && (ctrl_i.alu_op == ALUOP_BR)) begin
      cls_o = CL_BEQ;
    end else if (!ctrl_i.reg_dst && ctrl_i.alu_src && !ctrl_i.mem_to_reg && ctrl_i.reg_write &&
                 !ctrl_i.mem_read && !ctrl_i.mem_write && !ctrl_i.branch &&
                 (ctrl_i.alu_op == ALUOP_MEM)) begin
      cls_o = CL_ADDI;
    end else begin
      cls_o = CL_ILLEGAL;
    end
  end

  always_comb begin
    case (cls_o)
      CL_R:    op_o = OP_RTYPE;
      CL_LW:   op_o = OP_LW;
      CL_SW:   op_o = OP_SW;
      CL_BEQ:  op_o = OP_BEQ;
      CL_ADDI: op_o = OP_ADDI;
      default: op_o = 6'b000000;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: classifies a control bundle, assembles the instruction word
// and streams it into instruction memory through a two-stage ready/valid pipe.
module instr_encoder
  import mips_pkg::*;
#(
  parameter int               ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              reg_dst,
  input  logic              branch,
  input  logic              mem_read,
  input  logic              mem_to_reg,
  input  logic              mem_write,
  input  logic              alu_src,
  input  logic              reg_write,
  input  logic [1:0]        alu_op,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [5:0]        funct,
  input  logic [15:0]       imm,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   instr_count,
  output logic              full,
  output logic              err,
  input  logic              err_clr
);

  ctrl_bundle_t ctrl_s;
  instr_class_e cls_s;
  logic [5:0]   op_s;
  logic         legal_s, accept_s, acc_legal_s, acc_illegal_s;
  logic         s2_adv_s, s1_move_s, wr_done_s;

  logic              rdy_en_q, rdy_en_d;
  logic              s1_valid_q, s1_valid_d;
  logic              s1_rtype_q, s1_rtype_d;
  logic [5:0]        s1_op_q, s1_op_d;
  logic [4:0]        s1_rs_q, s1_rs_d, s1_rt_q, s1_rt_d, s1_rd_q, s1_rd_d, s1_shamt_q, s1_shamt_d;
  logic [5:0]        s1_funct_q, s1_funct_d;
  logic [15:0]       s1_imm_q, s1_imm_d;
  logic              s2_valid_q, s2_valid_d;
  logic [31:0]       s2_word_q, s2_word_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W:0]   slots_q, slots_d;
  logic              err_q, err_d;

  assign ctrl_s = {reg_dst, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, alu_op};

  ctrl_classify u_classify (
    .ctrl_i (ctrl_s),
    .cls_o  (cls_s),
    .op_o   (op_s)
  );

  // slots_q/count_q never exceed 2^ADDR_W, so their MSB alone flags "at capacity".
  assign legal_s       = (cls_s != CL_ILLEGAL);
  assign s2_adv_s      = !s2_valid_q || imem_ready;
  assign s1_move_s     = s1_valid_q && s2_adv_s;
  assign in_ready      = rdy_en_q && !slots_q[ADDR_W] && (!s1_valid_q || s2_adv_s);
  assign accept_s      = in_valid && in_ready;
  assign acc_legal_s   = accept_s && legal_s;
  assign acc_illegal_s = accept_s && !legal_s;
  assign wr_done_s     = s2_valid_q && imem_ready;

  assign imem_we     = s2_valid_q;
  assign imem_addr   = addr_q;
  assign imem_wdata  = s2_word_q;
  assign instr_count = count_q;
  assign full        = count_q[ADDR_W];
  assign err         = err_q;

  always_comb begin
    rdy_en_d   = 1'b1;
    s1_valid_d = s1_valid_q;
    s1_rtype_d = s1_rtype_q;
    s1_op_d    = s1_op_q;
    s1_rs_d    = s1_rs_q;
    s1_rt_d    = s1_rt_q;
    s1_rd_d    = s1_rd_q;
    s1_shamt_d = s1_shamt_q;
    s1_funct_d = s1_funct_q;
    s1_imm_d   = s1_imm_q;
    s2_valid_d = s2_valid_q;
    s2_word_d  = s2_word_q;
    addr_d     = addr_q;
    count_d    = count_q;
    slots_d    = slots_q;
    err_d      = err_q;

    if (acc_legal_s) begin
      s1_valid_d = 1'b1;
      s1_rtype_d = (cls_s == CL_R);
      s1_op_d    = op_s;
      s1_rs_d    = rs;
      s1_rt_d    = rt;
      s1_rd_d    = rd;
      s1_shamt_d = shamt;
      s1_funct_d = funct;
      s1_imm_d   = imm;
      slots_d    = slots_q + (ADDR_W+1)'(1);
    end else if (s1_move_s) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end

    // The word is held while stalled; an emptied S2 keeps its last word with we=0.
    if (s2_adv_s) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_word_d = encode_word(s1_rtype_q, s1_op_q, s1_rs_q, s1_rt_q, s1_rd_q,
                                s1_shamt_q, s1_funct_q, s1_imm_q);
      end else begin
        s2_word_d = s2_word_q;
      end
    end else begin
      s2_valid_d = s2_valid_q;
    end

    if (wr_done_s) begin
      count_d = count_q + (ADDR_W+1)'(1);
      if (addr_q != '1) begin
        addr_d = addr_q + ADDR_W'(1);
      end else begin
        addr_d = addr_q;
      end
    end else begin
      count_d = count_q;
    end

    if (acc_illegal_s) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en_q   <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_rtype_q <= 1'b0;
      s1_op_q    <= 6'd0;
      s1_rs_q    <= 5'd0;
      s1_rt_q    <= 5'd0;
      s1_rd_q    <= 5'd0;
      s1_shamt_q <= 5'd0;
      s1_funct_q <= 6'd0;
      s1_imm_q   <= 16'd0;
      s2_valid_q <= 1'b0;
      s2_word_q  <= 32'd0;
      addr_q     <= BASE_ADDR;
      count_q    <= '0;
      slots_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      rdy_en_q   <= rdy_en_d;
      s1_valid_q <= s1_valid_d;
      s1_rtype_q <= s1_rtype_d;
      s1_op_q    <= s1_op_d;
      s1_rs_q    <= s1_rs_d;
      s1_rt_q    <= s1_rt_d;
      s1_rd_q    <= s1_rd_d;
      s1_shamt_q <= s1_shamt_d;
      s1_funct_q <= s1_funct_d;
      s1_imm_q   <= s1_imm_d;
      s2_valid_q <= s2_valid_d;
      s2_word_q  <= s2_word_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      slots_q    <= slots_d;
      err_q      <= err_d;
    end
  end

endmodule
